multi_cycle_mem_responder: RTL and testbench

Memory-side responder for the cache fill protocol. The cache controller's miss FSM drives enable/wr/addr/data_in; this block services each request from a single-port word array and returns read data with data_valid exactly LATENCY cycles after issue. It is fully pipelined, so one request may be issued per cycle and reads may overlap. It is the unified backing store under the instruction cache and data cache.

---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_latency_pipe.sv | 37 +++
 rtl/multi_cycle_mem_responder.sv | 67 ++++++
 tb/tb_multi_cycle_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the cache fill memory path.
// Imported by the responder and the cache miss FSM.
package mem_pkg;

  localparam int WORD_W              = 16;
  localparam int DEFAULT_MEM_LATENCY = 4;
  localparam int DEFAULT_MEM_ADDR_W  = 10;

endpackage

// File: rtl/mem_latency_pipe.sv
// Fixed-depth {valid, data} shift pipeline with async clear.
// Exposes the valid vector so the parent can count in-flight reads.
module mem_latency_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DEPTH-1:0] valid_vec
);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign valid_vec = valid_q;

endmodule

// File: rtl/multi_cycle_mem_responder.sv
// Pipelined word-array responder under the I$ and D$ fill path.
// Reads sample the array at issue and return LATENCY cycles later.
module multi_cycle_mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_MEM_LATENCY,
  parameter int ADDR_W  = DEFAULT_MEM_ADDR_W,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [15:0]       addr,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic [CNT_W-1:0]  outstanding,
  output logic              busy
);

  logic [WORD_W-1:0]  mem [2**ADDR_W];
  logic [ADDR_W-1:0]  idx;
  logic               pipe_valid;
  logic [WORD_W-1:0]  pipe_data;
  logic [LATENCY-1:0] valid_vec;
  logic [CNT_W-1:0]   cnt;
  logic               unused_addr;

  assign idx         = addr[ADDR_W:1];
  assign unused_addr = ^{addr[0], addr[15:ADDR_W+1]};

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enable && wr) begin
      mem[idx] <= data_in;
    end
  end

  mem_latency_pipe #(
    .DEPTH (LATENCY),
    .WIDTH (WORD_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (enable & ~wr),
    .in_data   (mem[idx]),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .valid_vec (valid_vec)
  );

  // Stage data is loaded every cycle, so gate it on the valid bit.
  assign data_valid = pipe_valid;
  assign data_out   = pipe_valid ? pipe_data : '0;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < LATENCY; i++) begin
      cnt = cnt + CNT_W'(valid_vec[i]);
    end
  end

  assign outstanding = cnt;
  assign busy        = (cnt != '0);

endmodule

// File: tb/tb_multi_cycle_mem_responder.sv
// Randomized bench for multi_cycle_mem_responder.
// Compares every cycle against a queue-based timing model.
module tb_multi_cycle_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  outstanding;
  logic        busy;

  multi_cycle_mem_responder #(
    .LATENCY (LAT),
    .ADDR_W  (10),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .wr          (wr),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .outstanding (outstanding),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ret;
    logic [15:0] d;
    bit          k;
  } rd_t;

  rd_t         q[$];
  logic [15:0] mem_m [1024];
  bit          known [1024];
  int          cyc;
  int          n_tests;
  int          n_fail;
  int          pulses;
  int          peak;
  logic [15:0] last_dout;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic e, input logic w,
                      input logic [15:0] a,
                      input logic [15:0] d);
    int  i;
    bit  ev;
    rd_t r;
    @(negedge clk);
    enable  = e;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    cyc++;
    i = int'(a[10:1]);
    if (e && !w) begin
      r.ret = cyc + LAT - 1;
      r.d   = mem_m[i];
      r.k   = known[i];
      q.push_back(r);
    end
    if (e && w) begin
      mem_m[i] = d;
      known[i] = 1'b1;
    end
    while (q.size() > 0 && q[0].ret < cyc) void'(q.pop_front());
    #1;
    ev = (q.size() > 0) && (q[0].ret == cyc);
    check("valid", 32'(data_valid), 32'(ev));
    if (ev && q[0].k) check("data", 32'(data_out), 32'(q[0].d));
    if (!ev) check("data_idle", 32'(data_out), 32'h0);
    check("outstanding", 32'(outstanding), 32'(q.size()));
    check("busy", 32'(busy), 32'(q.size() != 0));
    if (data_valid) begin
      pulses++;
      last_dout = data_out;
    end
    if (int'(outstanding) > peak) peak = int'(outstanding);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b1;
    #1;
    q.delete();
    check("rst_outstanding", 32'(outstanding), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    @(posedge clk);
    cyc++;
    #1;
    check("rst_hold_valid", 32'(data_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        e;
    logic        w;
    logic [15:0] a;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    pulses  = 0;
    peak    = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_m[i] = '0;
      known[i] = 1'b0;
    end

    do_reset();

    // Write then read.
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    idle(5);
    check("beef", 32'(last_dout), 32'hBEEF);

    // Burst fill.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 16'(16'h0020 + 2 * i), 16'(16'h1000 + i));
    pulses = 0;
    peak   = 0;
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 16'(16'h0020 + 2 * i), 16'h0);
    idle(5);
    check("burst_pulses", 32'(pulses), 32'd8);
    check("burst_peak", 32'(peak), 32'd4);
    check("burst_last", 32'(last_dout), 32'h1007);
    check("burst_busy", 32'(busy), 32'h0);

    // Pre-write sampling.
    step(1'b1, 1'b1, 16'h0040, 16'hAAAA);
    step(1'b1, 1'b0, 16'h0040, 16'h0);
    step(1'b1, 1'b1, 16'h0040, 16'h5555);
    idle(4);
    check("prewrite", 32'(last_dout), 32'hAAAA);
    step(1'b1, 1'b0, 16'h0040, 16'h0);
    idle(4);
    check("postwrite", 32'(last_dout), 32'h5555);

    // Aliasing, then idle.
    step(1'b1, 1'b1, 16'h0802, 16'h1234);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    idle(4);
    check("alias", 32'(last_dout), 32'h1234);
    pulses = 0;
    idle(10);
    check("idle_pulses", 32'(pulses), 32'd0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 16'(16'h0020 + 2 * i), 16'h0);
    pulses = 0;
    do_reset();
    idle(8);
    check("rst_burst_pulses", 32'(pulses), 32'd0);

    // Randomized traffic over a small aliased window.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        e = 1'($urandom_range(0, 3) != 0);
        w = 1'($urandom_range(0, 2) == 0);
        a = {5'($urandom), 4'b0, 6'($urandom), 1'($urandom)};
        step(e, w, a, 16'($urandom));
      end
    end
    idle(LAT + 2);
    check("final_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
